audio_voice_scheduler: RTL

Per-sample scheduler that shares the single DAC sample slot between up to NUM_VOICES synth voice generators. On each sample tick it polls every enabled voice in fixed index order over a shared req/ack/data bus, then sums the returned signed samples. It saturates the sum to DATA_WIDTH and hands one word per frame to the I2S serializer. It sits between the voice generators and the DAC serializer in the 18.432 MHz domain.

---
 rtl/audio_sched_pkg.sv | 16 +
 rtl/sample_saturator.sv | 28 ++
 rtl/audio_voice_scheduler.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/audio_sched_pkg.sv
// Shared types and helpers for the voice scheduler and its saturator.
package audio_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_REQ  = 2'd2,
        ST_SAT  = 2'd3
    } sched_state_e;

    // Accumulator wide enough that summing nv full-scale samples never wraps.
    function automatic int unsigned acc_width(input int unsigned nv, input int unsigned dw);
        return dw + $clog2(nv);
    endfunction

endpackage

// File: rtl/sample_saturator.sv
// Combinational signed clamp from accumulator width down to sample width.
module sample_saturator #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 19
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    output logic signed [DATA_WIDTH-1:0] sample_c,
    output logic                         clip_c
);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    always_comb begin
        sample_c = acc[DATA_WIDTH-1:0];
        clip_c   = 1'b0;
        if (acc > SAT_MAX) begin
            sample_c = SAT_MAX[DATA_WIDTH-1:0];
            clip_c   = 1'b1;
        end else if (acc < SAT_MIN) begin
            sample_c = SAT_MIN[DATA_WIDTH-1:0];
            clip_c   = 1'b1;
        end
    end

endmodule

// File: rtl/audio_voice_scheduler.sv
// Polls enabled voices once per sample tick over a shared req/ack bus,
// sums their samples and hands one saturated word per frame to the DAC path.
module audio_voice_scheduler
    import audio_sched_pkg::*;
#(
    parameter int unsigned NUM_VOICES  = 8,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ACC_WIDTH   = acc_width(NUM_VOICES, DATA_WIDTH),
    parameter int unsigned ACK_TIMEOUT = 32,
    parameter int unsigned FRAME_CLKS  = 384
) (
    input  logic                  iCLK_18_4,
    input  logic                  iRST_N,
    input  logic                  iSample_Tick,
    input  logic [NUM_VOICES-1:0] iVoice_En,
    output logic [NUM_VOICES-1:0] oVoice_Req,
    input  logic                  iVoice_Ack,
    input  logic [DATA_WIDTH-1:0] iVoice_Data,
    input  logic                  iClr_Flags,
    output logic [DATA_WIDTH-1:0] oSample,
    output logic                  oSample_Valid,
    output logic                  oBusy,
    output logic                  oOverrun,
    output logic [NUM_VOICES-1:0] oTimeout,
    output logic                  oClip
);

    localparam int unsigned IDX_W = $clog2(NUM_VOICES);
    localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);

    sched_state_e                 state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [TMR_W-1:0]             timer_q, timer_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [NUM_VOICES-1:0]        en_q, en_d;
    logic [NUM_VOICES-1:0]        req_q, req_d;
    logic [DATA_WIDTH-1:0]        sample_q, sample_d;
    logic                         valid_q, valid_d;
    logic                         busy_q, busy_d;
    logic                         overrun_q, overrun_d;
    logic [NUM_VOICES-1:0]        timeout_q, timeout_d;
    logic                         clip_q, clip_d;

    logic signed [DATA_WIDTH-1:0] sat_sample_c;
    logic                         sat_clip_c;
    logic                         last_idx_c;

    sample_saturator #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_sat (
        .acc      (acc_q),
        .sample_c (sat_sample_c),
        .clip_c   (sat_clip_c)
    );

    assign last_idx_c = (idx_q == IDX_W'(NUM_VOICES - 1));

    always_ff @(posedge iCLK_18_4) begin
        assert (NUM_VOICES * (ACK_TIMEOUT + 2) + 3 <= FRAME_CLKS)
            else $error("voice scan cannot fit in one frame");
    end

    always_ff @(posedge iCLK_18_4) begin
        if (!iRST_N) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            timer_q   <= '0;
            acc_q     <= '0;
            en_q      <= '0;
            req_q     <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= '0;
            clip_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            acc_q     <= acc_d;
            en_q      <= en_d;
            req_q     <= req_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            clip_q    <= clip_d;
        end
    end

    // REQ has two phases: request held (req_q != 0) and one drop cycle before moving on.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        acc_d     = acc_q;
        en_d      = en_q;
        req_d     = req_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        overrun_d = iClr_Flags ? 1'b0 : overrun_q;
        timeout_d = iClr_Flags ? '0   : timeout_q;
        clip_d    = iClr_Flags ? 1'b0 : clip_q;

        if (iSample_Tick && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (iSample_Tick) begin
                    en_d    = iVoice_En;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (en_q[idx_q]) begin
                    timer_d = '0;
                    req_d   = NUM_VOICES'(1) << idx_q;
                    state_d = ST_REQ;
                end else if (last_idx_c) begin
                    state_d = ST_SAT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_REQ: begin
                if (req_q != '0) begin
                    if (iVoice_Ack) begin
                        acc_d = acc_q + {{(ACC_WIDTH-DATA_WIDTH){iVoice_Data[DATA_WIDTH-1]}},
                                         iVoice_Data};
                        req_d = '0;
                    end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                        timeout_d[idx_q] = 1'b1;
                        req_d            = '0;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end else if (last_idx_c) begin
                    state_d = ST_SAT;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_SCAN;
                end
            end
            ST_SAT: begin
                sample_d = sat_sample_c;
                valid_d  = 1'b1;
                if (sat_clip_c) begin
                    clip_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign oVoice_Req    = req_q;
    assign oSample       = sample_q;
    assign oSample_Valid = valid_q;
    assign oBusy         = busy_q;
    assign oOverrun      = overrun_q;
    assign oTimeout      = timeout_q;
    assign oClip         = clip_q;

endmodule
